// File: rtl/cordic_vector_iter.sv
// Iterative circular CORDIC, vectoring mode: (x, y) -> (magnitude * K, angle in BAM).
// Latency: ITERS cycles from accept to out_valid; one request in flight, min period ITERS+2.
// Backpressure: result held stable in DONE until out_ready; in_ready is low outside IDLE.
// Ports: clk/reset (async, active-high); in_valid/in_ready/x_in/y_in request side;
//        out_valid/out_ready/mag_out/angle_out result side. mag_out is uncompensated
//        (includes gain K), angle_out uses 0x4000 = +pi/2, 0x8000 = +/-pi.
module cordic_vector_iter #(
  parameter int ITERS = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic signed [15:0] x_in,
  input  logic signed [15:0] y_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [17:0]        mag_out,
  output logic [15:0]        angle_out
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state, state_nxt;
  logic [3:0]         iter;
  logic signed [17:0] x_r, y_r;
  logic [15:0]        z_r;
  logic               zero_r;
  logic               in_ready_r;

  logic               accept;
  logic               last_iter;
  logic signed [17:0] x_ext, y_ext;
  logic signed [17:0] x_sh, y_sh;
  logic [15:0]        atan_i;

  // atan(2^-i) in BAM, rounded to nearest.
  function automatic logic [15:0] atan_lut(input logic [3:0] i);
    case (i)
      4'd0:    atan_lut = 16'h2000;
      4'd1:    atan_lut = 16'h12E4;
      4'd2:    atan_lut = 16'h09FB;
      4'd3:    atan_lut = 16'h0511;
      4'd4:    atan_lut = 16'h028B;
      4'd5:    atan_lut = 16'h0146;
      4'd6:    atan_lut = 16'h00A3;
      4'd7:    atan_lut = 16'h0051;
      4'd8:    atan_lut = 16'h0029;
      4'd9:    atan_lut = 16'h0014;
      4'd10:   atan_lut = 16'h000A;
      4'd11:   atan_lut = 16'h0005;
      4'd12:   atan_lut = 16'h0003;
      4'd13:   atan_lut = 16'h0001;
      4'd14:   atan_lut = 16'h0001;
      default: atan_lut = 16'h0000;
    endcase
  endfunction

  // Two guard bits: -32768 negates cleanly and the K-scaled magnitude (~76300) fits.
  assign x_ext     = {{2{x_in[15]}}, x_in};
  assign y_ext     = {{2{y_in[15]}}, y_in};
  assign x_sh      = x_r >>> iter;
  assign y_sh      = y_r >>> iter;
  assign atan_i    = atan_lut(iter);
  assign last_iter = (iter == 4'(ITERS - 1));
  assign accept    = (state == IDLE) && in_valid && in_ready_r;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = RUN;
      RUN:     if (last_iter) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      in_ready_r <= 1'b0;
      iter       <= 4'd0;
      x_r        <= '0;
      y_r        <= '0;
      z_r        <= '0;
      zero_r     <= 1'b0;
    end else begin
      state      <= state_nxt;
      // Registered ready: high exactly when the next state is IDLE.
      in_ready_r <= (state_nxt == IDLE);
      if (accept) begin
        iter   <= 4'd0;
        zero_r <= (x_in == 16'sd0) && (y_in == 16'sd0);
        // Left half-plane: rotate by pi so iterations only need to cover +/-pi/2.
        if (x_in[15]) begin
          x_r <= -x_ext;
          y_r <= -y_ext;
          z_r <= 16'h8000;
        end else begin
          x_r <= x_ext;
          y_r <= y_ext;
          z_r <= 16'h0000;
        end
      end else if (state == RUN) begin
        if (!y_r[17]) begin
          x_r <= x_r + y_sh;
          y_r <= y_r - x_sh;
          z_r <= z_r + atan_i;
        end else begin
          x_r <= x_r - y_sh;
          y_r <= y_r + x_sh;
          z_r <= z_r - atan_i;
        end
        if (!last_iter) iter <= iter + 4'd1;
      end
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = (state == DONE);
  // Gated so outputs read zero outside DONE, including immediately on reset.
  assign mag_out   = out_valid ? $unsigned(x_r) : 18'd0;
  // atan2(0,0) is undefined; report 0 rather than the accumulated z.
  assign angle_out = (out_valid && !zero_r) ? z_r : 16'h0000;

endmodule

// File: doc/cordic_vector_iter.md
# cordic_vector_iter

Iterative circular CORDIC in vectoring mode: it converts a Cartesian pair (x, y) into polar magnitude and angle by driving y toward zero, one micro-rotation per clock. It is the inverse counterpart of the pipelined rotation-mode datapath, which turns an angle into (x, y). It sits behind sample producers that need atan2/magnitude at low throughput and trades area for a 16-cycle latency. Input and output use valid/ready handshakes.

## Interface
- ITERS, 16, number of micro-rotations performed (legal 1..16); the atan table holds 16 entries
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  reset, asynchronous, active-high
- in_valid  input  1  x_in/y_in hold a request
- in_ready  output  1  block can accept a request (registered)
- x_in  input  16  signed Cartesian x
- y_in  input  16  signed Cartesian y
- out_valid  output  1  mag_out/angle_out valid
- out_ready  input  1  consumer accepts result
- mag_out  output  18  unsigned magnitude with CORDIC gain K included (uncompensated)
- angle_out  output  16  angle in binary angle units (BAM): 0x4000 = +pi/2, 0x8000 = ±pi, wraps mod 2^16

## Operation
- FSM states: IDLE, RUN, DONE. Reset enters IDLE.
- IDLE:
  - in_ready = 1.
  - On in_valid, the request is accepted. Load sign-extended 18-bit x/y, set iter = 0, go to RUN.
- Pre-rotation at load:
  - If x_in < 0, load x = -x_in, y = -y_in, z = 0x8000.
  - Otherwise load x = x_in, y = y_in, z = 0.
  - x_in = -32768 must negate to +32768 without wrap; the 18-bit datapath covers this.
- Zero flag: registered at load, set when x_in = 0 and y_in = 0.
- RUN, one iteration per cycle, with i = iter and all three updates using pre-update values:
  - If y ≥ 0: x += y>>>i, y -= x>>>i, z += atan[i].
  - If y < 0: x -= y>>>i, y += x>>>i, z -= atan[i].
  - Shifts are arithmetic. z arithmetic is 16-bit and wraps.
  - When iter = ITERS-1, go to DONE. Otherwise iter += 1.
- atan[i] (BAM, round-to-nearest of atan(2^-i)·32768/pi), i = 0..15: 0x2000, 0x12E4, 0x09FB, 0x0511, 0x028B, 0x0146, 0x00A3, 0x0051, 0x0029, 0x0014, 0x000A, 0x0005, 0x0003, 0x0001, 0x0001, 0x0000.
- DONE:
  - out_valid = 1. mag_out = x[17:0]. angle_out = zero flag ? 0x0000 : z.
  - Outputs are stable while out_valid && !out_ready.
  - On out_ready, go to IDLE.
- Magnitude gain K = 1.64676 for ITERS = 16. The maximum |(x,y)|·K is about 76 300, which fits in 18 bits with no saturation.
- No input is accepted outside IDLE; in_ready = 0 in RUN and DONE.

## Timing
- Reset values: in_ready = 0, out_valid = 0, mag_out = 0, angle_out = 0, state IDLE, iter = 0.
- in_ready rises on the first clk edge after reset deasserts.
- Accept at edge N (in_valid && in_ready). in_ready is low from N.
- Iterations occur on edges N+1 .. N+ITERS. out_valid is high after edge N+ITERS (latency ITERS cycles).
- Result handshake: the result transfers at the edge where out_valid && out_ready. out_valid drops and in_ready rises after that edge.
- Minimum request period: ITERS + 2 cycles.
- out_ready held high before DONE has no effect; out_valid is still asserted for at least one cycle.
- in_valid during RUN/DONE is ignored. The producer must hold the request until it is accepted.
- reset asserted mid-RUN or mid-DONE: the in-flight result is discarded, all outputs return to reset values immediately, and no out_valid is produced for that request.

## Test plan
- Reset/idle: assert reset mid-RUN → out_valid = 0, mag_out = 0, angle_out = 0 at once; in_ready = 1 one edge after release; the next request completes normally.
- Axes: (10000, 0) → angle 0x0000 ±4, mag 16468 ±8. (0, 10000) → 0x4000 ±4. (0, -10000) → 0xC000 ±4. (-10000, 0) → 0x8000 ±4, mag 16468 ±8 each.
- General: (3000, -4000) → angle 0xDA38 ±4, mag 8234 ±8. Extremes: (-32768, -32768) → angle 0xA000 ±4, mag 76312 ±16, no overflow.
- Zero: (0, 0) → mag 0, angle exactly 0x0000.
- Latency/handshake: accept at edge N → out_valid first high after edge N+16. Hold out_ready = 0 for 5 cycles → outputs constant and in_ready = 0. Release → out_valid low and in_ready high next cycle. in_valid pulsed during RUN → ignored.
- Random: 10 000 random (x, y) pairs with random out_ready back-pressure → every request produces exactly one result, in order. Angle error ≤ 4 LSB versus a reference atan2; magnitude error ≤ 0.05% versus K·hypot.
